// File: rtl/uart_tx_bridge.sv
// Byte FIFO feeding a UART 8N1 transmitter; bytes written on wr_en, sent LSB first on tx.
// Optional even-parity cell between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_bridge #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_AW      = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [7:0]         wr_data,
   input  logic               wr_en,
   output logic               ready,
   output logic               tx,
   output logic               busy,
   output logic               overflow,
   output logic [FIFO_AW:0]   fifo_count
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int CW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [FIFO_AW:0] FULL      = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2:0]           idx_q, idx_d;
   logic [7:0]           shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 ovf_q;
   logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]     count_q, count_d;
   logic [7:0]           mem [DEPTH];
   logic [7:0]           head;
   logic                 push, pop, baud_last;
`ifdef UART_TX_PARITY_EN
   logic                 parity_q, parity_d;
`endif

   assign ready      = (count_q != FULL);
   assign busy       = (state_q != S_IDLE);
   assign overflow   = ovf_q;
   assign fifo_count = count_q;
   assign tx         = tx_q;
   assign head       = mem[rd_ptr_q];
   assign push       = wr_en & ready;
   assign baud_last  = (cnt_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      cnt_d   = baud_last ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            pop   = (count_q != '0);
         end
         S_START: begin
            tx_d = 1'b0;
            if (baud_last) begin
               state_d = S_DATA;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            tx_d = shift_q[0];
            if (baud_last) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
               if (idx_q == 3'd7) state_d = S_PARITY;
`else
               if (idx_q == 3'd7) state_d = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            tx_d = parity_q;
            if (baud_last) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               state_d = S_IDLE;
               pop     = (count_q != '0);
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Popping from STOP chains straight into the next START with no idle cell.
      if (pop) begin
         state_d = S_START;
         cnt_d   = '0;
         shift_d = head;
`ifdef UART_TX_PARITY_EN
         parity_d = ^head;
`endif
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         count_q  <= count_d;
         if (wr_en && !ready) ovf_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Directed bench for uart_tx_bridge at CLKS_PER_BIT=4, FIFO_AW=3; follows UART_TX_PARITY_EN.
module tb_uart_tx_bridge;
   localparam int CPB = 4;
   localparam int AW  = 3;
`ifdef UART_TX_PARITY_EN
   localparam int NCELL = 11;
`else
   localparam int NCELL = 10;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_en = 1'b0;
   logic          ready, tx, busy, overflow;
   logic [AW:0]   fifo_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic [9:0] cells;   // start at bit 0, data LSB first, stop at bit 9
      logic       par;
   } vec_t;
   vec_t tbl [7];

   logic [7:0] vals [10];
   int         exp_cnt [10];

   uart_tx_bridge #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .clock(clock), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
      .ready(ready), .tx(tx), .busy(busy), .overflow(overflow), .fifo_count(fifo_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic wait_start(input int budget, input string nm, output int t);
      for (int i = 0; i < budget && tx !== 1'b0; i++) tick(1);
      if (tx !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL %s_start_timeout: tx got %b expected 0", nm, tx);
      end
      t = cyc;
   endtask

   // Called on the first cycle tx is seen low; samples each cell in its middle.
   task automatic read_frame(input logic [9:0] cells, input logic p, input string nm);
      logic [10:0] exp;
`ifdef UART_TX_PARITY_EN
      exp = {cells[9], p, cells[8:0]};
`else
      exp = {p, cells};
`endif
      tick(CPB / 2);
      for (int k = 0; k < NCELL; k++) begin
         if (k > 0) tick(CPB);
         chk($sformatf("%s_cell%0d", nm, k), tx, exp[k]);
      end
   endtask

   task automatic single_frame(input logic [7:0] d, input logic [9:0] cells, input logic p,
                               input string nm);
      wr_data = d;
      wr_en   = 1'b1;
      tick(1);
      wr_en   = 1'b0;
      wr_data = ~d;
      chk({nm, "_cnt_after_wr"}, fifo_count, 1);
      chk({nm, "_busy_after_wr"}, busy, 0);
      chk({nm, "_tx_after_wr"}, tx, 1);
      tick(1);
      chk({nm, "_busy_at_pop"}, busy, 1);
      chk({nm, "_cnt_at_pop"}, fifo_count, 0);
      chk({nm, "_tx_at_pop"}, tx, 1);
      tick(1);
      read_frame(cells, p, nm);
      chk({nm, "_busy_last"}, busy, 1);
      tick(1);
      chk({nm, "_busy_end"}, busy, 0);
      chk({nm, "_tx_end"}, tx, 1);
   endtask

   initial begin
      int t1, t2;
      tbl[0] = '{8'h55, 10'b1010101010, 1'b0};
      tbl[1] = '{8'hA3, 10'b1101000110, 1'b0};
      tbl[2] = '{8'h0F, 10'b1000011110, 1'b0};
      tbl[3] = '{8'hFF, 10'b1111111110, 1'b0};
      tbl[4] = '{8'h00, 10'b1000000000, 1'b0};
      tbl[5] = '{8'h80, 10'b1100000000, 1'b1};
      tbl[6] = '{8'h07, 10'b1000001110, 1'b1};
      vals    = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hA5, 8'hC3, 8'h3C, 8'h81, 8'h99};
      exp_cnt = '{1, 1, 2, 3, 4, 5, 6, 7, 8, 8};

      tick(2);
      chk("rst_ready", ready, 1);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_count", fifo_count, 0);
      reset = 1'b0;
      tick(1);

      for (int v = 0; v < 7; v++)
         single_frame(tbl[v].data, tbl[v].cells, tbl[v].par, $sformatf("vec%0d", v));

      // Two queued bytes: second start bit must follow first stop bit directly.
      wr_data = 8'hA3; wr_en = 1'b1; tick(1);
      wr_data = 8'h0F; tick(1);
      wr_en = 1'b0;
      wait_start(10, "b2b_a", t1);
      read_frame(10'b1101000110, 1'b0, "b2b_a");
      wait_start(10, "b2b_b", t2);
      chk("b2b_gap", t2 - t1, NCELL * CPB);
      read_frame(10'b1000011110, 1'b0, "b2b_b");
      tick(3);
      chk("b2b_idle", busy, 0);

      // Ten back-to-back writes: nine accepted, tenth dropped, nine frames in order.
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               wr_data = vals[i];
               wr_en   = 1'b1;
               tick(1);
               chk($sformatf("fill_cnt%0d", i), fifo_count, exp_cnt[i]);
               chk($sformatf("fill_ready%0d", i), ready, (i < 8) ? 1 : 0);
               chk($sformatf("fill_ovf%0d", i), overflow, (i == 9) ? 1 : 0);
            end
            wr_en   = 1'b0;
            wr_data = 8'hEE;
         end
         begin
            int t;
            for (int k = 0; k < 9; k++) begin
               wait_start(100, $sformatf("fill_f%0d", k), t);
               read_frame({1'b1, vals[k], 1'b0}, ^vals[k], $sformatf("fill_f%0d", k));
            end
         end
      join
      tick(3);
      chk("fill_idle", busy, 0);
      chk("fill_empty", fifo_count, 0);
      chk("fill_ovf_sticky", overflow, 1);

      // Reset in the middle of a data cell clears everything without a clock edge.
      wr_data = 8'hFF; wr_en = 1'b1; tick(1);
      wr_data = 8'h12; tick(1);
      wr_en = 1'b0;
      wait_start(10, "abort", t1);
      tick(2 * CPB);
      chk("abort_pre_cnt", fifo_count, 1);
      chk("abort_pre_ovf", overflow, 1);
      chk("abort_pre_busy", busy, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_tx", tx, 1);
      chk("abort_busy", busy, 0);
      chk("abort_cnt", fifo_count, 0);
      chk("abort_ovf", overflow, 0);
      chk("abort_ready", ready, 1);
      tick(2);
      reset = 1'b0;
      tick(1);
      single_frame(8'h3C, 10'b1001111000, 1'b0, "post_rst");

      // Full FIFO, write on the same edge as the STOP-cell pop: write is dropped.
      reset = 1'b1; tick(1);
      reset = 1'b0; tick(1);
      for (int i = 0; i < 9; i++) begin
         wr_data = 8'h10 + 8'(i);
         wr_en   = 1'b1;
         tick(1);
      end
      wr_en = 1'b0;
      chk("full_cnt", fifo_count, 8);
      chk("full_ready", ready, 0);
      chk("full_ovf", overflow, 0);
      tick(NCELL * CPB - 8);
      chk("popedge_pre_cnt", fifo_count, 8);
      wr_data = 8'h99;
      wr_en   = 1'b1;
      tick(1);
      wr_en   = 1'b0;
      chk("popedge_cnt", fifo_count, 7);
      chk("popedge_ovf", overflow, 1);
      chk("popedge_ready", ready, 1);
      chk("popedge_busy", busy, 1);

      reset = 1'b1; tick(1);
      reset = 1'b0; tick(1);
      chk("final_ready", ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
